unid_busca: RTL and testbench

Instruction-fetch and sequencing stage that sits directly upstream of the control unit. It owns the program counter (PC) and requests each instruction from instruction memory over a req/valid handshake. It latches the instruction into the instruction register and drives `instrucao` and the 2-bit `step` sequence (0→3) that the control unit decodes. At step 3 it consumes the control unit's `pc_enable`/`pc_load` to advance or branch, then fetches the next instruction.

---
 rtl/unid_busca.sv | 121 ++++++++++++
 tb/tb_unid_busca.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/unid_busca.sv
// unid_busca: instruction fetch and sequencing stage.
// Owns the PC, fetches each instruction over a req/valid handshake, latches it
// into the instruction register and steps the control unit through 0..3.
module unid_busca #(
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic                clock,
    input  logic                resetn,      // active-high asynchronous reset
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic                mem_req,
    input  logic [15:0]         mem_data,
    input  logic                mem_valid,
    output logic [15:0]         instrucao,
    output logic [1:0]          step,
    output logic                exec_valid,
    input  logic                pc_enable,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_target,
    output logic                halted,
    output logic [PC_WIDTH-1:0] pc
);

    localparam int unsigned IR_WIDTH = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]          state_q,      state_d;
    logic [PC_WIDTH-1:0] pc_q,         pc_d;
    logic [IR_WIDTH-1:0] ir_q,         ir_d;
    logic [1:0]          step_q,       step_d;
    logic                idle_cnt_q,   idle_cnt_d;
    logic                mem_req_q,    mem_req_d;
    logic                exec_valid_q, exec_valid_d;
    logic                halted_q,     halted_d;

    // Next-state, PC/IR update and registered output flags decoded from the next state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        step_d     = step_q;
        idle_cnt_d = idle_cnt_q;

        case (state_q)
            S_IDLE: begin
                // IDLE spans one full cycle after reset release before fetching
                if (idle_cnt_q) begin
                    idle_cnt_d = 1'b0;
                    state_d    = S_FETCH;
                end else begin
                    idle_cnt_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (mem_valid) begin
                    ir_d    = mem_data;
                    step_d  = 2'd0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (step_q == 2'd3) begin
                    step_d = 2'd0;
                    if (pc_enable) begin
                        pc_d    = pc_load ? pc_target : pc_q + PC_WIDTH'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_HALT;
                    end
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            S_HALT: begin
                step_d = 2'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_req_d    = (state_d == S_FETCH);
        exec_valid_d = (state_d == S_EXEC);
        halted_d     = (state_d == S_HALT);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            step_q       <= 2'd0;
            idle_cnt_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            exec_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            step_q       <= step_d;
            idle_cnt_q   <= idle_cnt_d;
            mem_req_q    <= mem_req_d;
            exec_valid_q <= exec_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign mem_req    = mem_req_q;
    assign instrucao  = ir_q;
    assign step       = step_q;
    assign exec_valid = exec_valid_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_unid_busca.sv
// Directed bench for unid_busca: memory stub and control-unit stub driven inline,
// expected instruction words tracked in a scoreboard queue.
module tb_unid_busca;

    logic        clock;
    logic        resetn;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic [15:0] mem_data;
    logic        mem_valid;
    logic [15:0] instrucao;
    logic [1:0]  step;
    logic        exec_valid;
    logic        pc_enable;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic        halted;
    logic [7:0]  pc;

    int checks;
    int errors;
    logic [15:0] exp_q[$];

    unid_busca #(.PC_WIDTH(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid),
        .instrucao  (instrucao),
        .step       (step),
        .exec_valid (exec_valid),
        .pc_enable  (pc_enable),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .halted     (halted),
        .pc         (pc)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Absolute run-time bound
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard and compare against the instruction register
    task automatic check_ir(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=scoreboard_entry", tag, instrucao);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(instrucao), 32'(e));
        end
    endtask

    // Runs one instruction starting at a negedge in FETCH; ends at the negedge after step 3
    task automatic run_instr(input logic [15:0] word, input int waits, input bit spur,
                             input bit early, input logic en, input logic ld,
                             input logic [7:0] tgt, input logic [7:0] addr,
                             input logic [7:0] next_addr);
        check("fetch_req", 32'(mem_req), 32'd1);
        check("fetch_addr", 32'(mem_addr), 32'(addr));
        check("fetch_pc", 32'(pc), 32'(addr));
        for (int w = 0; w < waits; w++) begin
            mem_valid = 1'b0;
            mem_data  = 16'($urandom);
            @(negedge clock);
            check("wait_req", 32'(mem_req), 32'd1);
            check("wait_addr", 32'(mem_addr), 32'(addr));
        end
        mem_data  = word;
        mem_valid = 1'b1;
        exp_q.push_back(word);
        @(negedge clock);
        check("exec_valid", 32'(exec_valid), 32'd1);
        check("exec_req_low", 32'(mem_req), 32'd0);
        check("step0", 32'(step), 32'd0);
        check_ir("ir_latch");
        if (spur) begin
            mem_data  = ~word;
            mem_valid = 1'b1;
        end else begin
            mem_valid = 1'b0;
        end
        @(negedge clock);
        check("step1", 32'(step), 32'd1);
        if (early) begin
            pc_enable = 1'b1;
            pc_load   = 1'b1;
            pc_target = 8'h77;
        end
        @(negedge clock);
        pc_enable = 1'b0;
        pc_load   = 1'b0;
        pc_target = 8'h00;
        check("step2", 32'(step), 32'd2);
        @(negedge clock);
        check("step3", 32'(step), 32'd3);
        check("ir_hold", 32'(instrucao), 32'(word));
        pc_enable = en;
        pc_load   = ld;
        pc_target = tgt;
        @(negedge clock);
        pc_enable = 1'b0;
        pc_load   = 1'b0;
        pc_target = 8'h00;
        mem_valid = 1'b0;
        check("post_exec_valid", 32'(exec_valid), 32'd0);
        if (en) begin
            check("next_req", 32'(mem_req), 32'd1);
            check("next_addr", 32'(mem_addr), 32'(next_addr));
        end else begin
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_req", 32'(mem_req), 32'd0);
            check("halt_pc", 32'(pc), 32'(addr));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        resetn    = 1'b1;
        mem_data  = 16'h0000;
        mem_valid = 1'b0;
        pc_enable = 1'b0;
        pc_load   = 1'b0;
        pc_target = 8'h00;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_ir", 32'(instrucao), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_exec", 32'(exec_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // Release: IDLE for one full cycle, request on the 2nd rising edge
        resetn = 1'b0;
        @(negedge clock);
        check("idle_req", 32'(mem_req), 32'd0);
        @(negedge clock);

        // Sequential zero-wait fetches 0,1,2 (spurious valid during EXEC of the second)
        run_instr(16'h1111, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01);
        run_instr(16'h2222, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 8'h02);
        run_instr(16'h3333, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 8'h03);
        // Three wait states, then a spurious response during EXEC
        run_instr(16'h4444, 3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 8'h04);
        // Branch to 0x40 with an ignored pc_load pulse at step 1
        run_instr(16'h5555, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h04, 8'h40);
        // Branch to the top of the address space, then wrap on increment
        run_instr(16'h6666, 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h40, 8'hFF);
        run_instr(16'h7777, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00);
        run_instr(16'h8888, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01);

        // Reset asserted mid-EXEC at step 2 takes effect without a clock edge
        check("mid_addr", 32'(mem_addr), 32'h01);
        mem_data  = 16'h9999;
        mem_valid = 1'b1;
        exp_q.push_back(16'h9999);
        @(negedge clock);
        check_ir("mid_ir");
        mem_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("mid_step2", 32'(step), 32'd2);
        #2;
        resetn    = 1'b1;
        mem_data  = 16'hBEEF;
        mem_valid = 1'b1;
        #1;
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_step", 32'(step), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_ir", 32'(instrucao), 32'd0);
        check("arst_exec", 32'(exec_valid), 32'd0);
        @(negedge clock);
        mem_valid = 1'b0;
        resetn    = 1'b0;
        @(negedge clock);
        check("idle2_req", 32'(mem_req), 32'd0);
        check("idle2_ir", 32'(instrucao), 32'd0);
        @(negedge clock);

        // Halt on pc_enable=0 at step 3
        run_instr(16'hA5A5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 22; i++) begin
            mem_valid = 1'($urandom_range(0, 1));
            mem_data  = 16'($urandom);
            pc_enable = 1'($urandom_range(0, 1));
            @(negedge clock);
            check("halt_hold", 32'({halted, mem_req, exec_valid, step}), 32'b10000);
            check("halt_pc_hold", 32'(pc), 32'd0);
            check("halt_ir_hold", 32'(instrucao), 32'hA5A5);
        end
        mem_valid = 1'b0;
        pc_enable = 1'b0;

        // Reset clears halted
        resetn = 1'b1;
        #1;
        check("rst_clears_halt", 32'(halted), 32'd0);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("refetch_req", 32'(mem_req), 32'd1);
        check("refetch_addr", 32'(mem_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
